// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the CPU-side cache controller slice.
//   - cache_state_e : controller FSM states
//   - WORD_BYTES    : bytes per CPU word (word-aligned accesses only)
//   - clog2         : ceiling log2 usable in constant expressions
// ---------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CWR    = 3'd2,
        MWR    = 3'd3,
        RF_REQ = 3'd4,
        RF_WR  = 3'd5,
        DONE   = 3'd6
    } cache_state_e;

    localparam int WORD_BYTES = 4;

    // Ceiling log2; clog2(1) is 0, so callers needing a non-zero vector
    // width must clamp the result themselves.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/victim_sel.sv
// ---------------------------------------------------------------------------
// victim_sel
//   Round-robin victim pointer for refills. Holds a binary set index that
//   advances by one (wrapping after the last set) whenever advance_i is
//   high, and presents it as a one-hot set select.
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active-high (pointer back to set 0)
//   advance_i    : step to the next set after the current refill completes
//   setOneHot_o  : one-hot select of the current victim set
// ---------------------------------------------------------------------------
module victim_sel
    import cache_pkg::*;
#(
    parameter int NUMBER_OF_SETS = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      advance_i,
    output logic [NUMBER_OF_SETS-1:0] setOneHot_o
);

    localparam int VIDX_W = (NUMBER_OF_SETS > 1) ? clog2(NUMBER_OF_SETS) : 1;
    localparam logic [VIDX_W-1:0] LAST_SET = VIDX_W'(NUMBER_OF_SETS - 1);

    logic [VIDX_W-1:0] victim_q;
    logic [VIDX_W-1:0] victim_d;

    // Next victim: a single-set cache never moves; otherwise wrap after the
    // last set so the pointer visits every set in turn.
    always_comb begin
        victim_d = victim_q;
        if (NUMBER_OF_SETS == 1) begin
            victim_d = '0;
        end else if (advance_i) begin
            if (victim_q == LAST_SET) begin
                victim_d = '0;
            end else begin
                victim_d = victim_q + VIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            victim_q <= '0;
        end else begin
            victim_q <= victim_d;
        end
    end

    // Set index 0 maps to the most significant select bit, matching the
    // cache array's set numbering on its set_sel bus.
    always_comb begin
        setOneHot_o = NUMBER_OF_SETS'(1) << (NUMBER_OF_SETS - 1 - int'(victim_q));
    end

endmodule

// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
//   CPU-side controller in front of the cache array. Takes one word access
//   at a time, probes the cache, refills a missing block from memory word by
//   word and replays the lookup. Write-through, no write-allocate; refills
//   land in a round-robin victim set.
// Ports
//   clk_i, rst_i          : clock (rising edge), synchronous active-high reset
//   cpu_req_i/we_i        : access request (sampled only when idle), 1 = write
//   cpu_addr_i/wdata_i    : byte address (low word bits ignored), write data
//   cpu_rdata_o           : read data, valid while cpu_ready_o, held until
//                           the next read completes
//   cpu_ready_o           : one-cycle completion pulse
//   cache_addr_o          : cache address
//   cache_cs/we/re/rpe_o  : cache chip select, write, read, replace enables
//   cache_set_sel_o       : cache set select
//   cache_wdata_o/_oe_o   : data toward the cache bus and its drive enable
//   cache_rdata_i/hit_i   : cache bus read-back and combinational hit
//   mem_req_o/we_o        : memory request (held until ack) and write flag
//   mem_addr_o/wdata_o    : word-aligned memory address and write data
//   mem_rdata_i/ack_i     : memory read data and one-cycle completion
// ---------------------------------------------------------------------------
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUMBER_OF_SETS = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata_i,
    output logic [DATA_WIDTH-1:0]     cpu_rdata_o,
    output logic                      cpu_ready_o,
    output logic [ADDR_WIDTH-1:0]     cache_addr_o,
    output logic                      cache_cs_o,
    output logic                      cache_we_o,
    output logic                      cache_re_o,
    output logic                      cache_rpe_o,
    output logic [NUMBER_OF_SETS-1:0] cache_set_sel_o,
    output logic [DATA_WIDTH-1:0]     cache_wdata_o,
    output logic                      cache_wdata_oe_o,
    input  logic [DATA_WIDTH-1:0]     cache_rdata_i,
    input  logic                      cache_hit_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_ack_i
);

    localparam int NBEATS   = BLOCK_SIZE / WORD_BYTES;
    localparam int BEAT_W   = (NBEATS > 1) ? clog2(NBEATS) : 1;
    localparam int WORD_OFF = clog2(WORD_BYTES);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ADDR_WIDTH'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(NBEATS - 1);

    cache_state_e state_q, state_d;

    logic                  we_q,    we_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] fill_q,  fill_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BEAT_W-1:0]     beat_q,  beat_d;

    logic                      victimAdvance;
    logic [NUMBER_OF_SETS-1:0] victimOneHot;
    logic [ADDR_WIDTH-1:0]     refillAddr;

    victim_sel #(
        .NUMBER_OF_SETS (NUMBER_OF_SETS)
    ) u_victim_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .advance_i   (victimAdvance),
        .setOneHot_o (victimOneHot)
    );

    // Refill beats walk the block from its base; the beat counter is only
    // cleared on entry to a refill, so it never wraps on its own.
    always_comb begin
        refillAddr = (addr_q & ~BLOCK_MASK) | (ADDR_WIDTH'(beat_q) << WORD_OFF);
    end

    // Next-state logic. A read miss loops RF_REQ/RF_WR once per beat and then
    // goes back to LOOKUP, where the replay is expected to hit and return the
    // data exactly like an ordinary read hit.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        fill_d        = fill_q;
        rdata_d       = rdata_q;
        beat_d        = beat_q;
        victimAdvance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i & ~WORD_MASK;
                    wdata_d = cpu_wdata_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit_i) begin
                    if (we_q) begin
                        state_d = CWR;
                    end else begin
                        rdata_d = cache_rdata_i;
                        state_d = DONE;
                    end
                end else if (we_q) begin
                    state_d = MWR;
                end else begin
                    beat_d  = '0;
                    state_d = RF_REQ;
                end
            end
            CWR: begin
                state_d = MWR;
            end
            MWR: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                end
            end
            RF_REQ: begin
                if (mem_ack_i) begin
                    fill_d  = mem_rdata_i;
                    state_d = RF_WR;
                end
            end
            RF_WR: begin
                if (beat_q == LAST_BEAT) begin
                    victimAdvance = 1'b1;
                    state_d       = LOOKUP;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = RF_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registers. Reset also clears the returned read data so every output
    // reads zero in the cycle after reset, even mid-refill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
        end
    end

    // Output decode. Everything idles at zero; the data bus is only driven in
    // the two cache-write states, which never coincide with a cache read.
    always_comb begin
        cpu_rdata_o      = rdata_q;
        cpu_ready_o      = 1'b0;
        cache_addr_o     = '0;
        cache_cs_o       = 1'b0;
        cache_we_o       = 1'b0;
        cache_re_o       = 1'b0;
        cache_rpe_o      = 1'b0;
        cache_set_sel_o  = '0;
        cache_wdata_o    = '0;
        cache_wdata_oe_o = 1'b0;
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;
        unique case (state_q)
            LOOKUP: begin
                cache_cs_o      = 1'b1;
                cache_re_o      = 1'b1;
                cache_set_sel_o = '1;
                cache_addr_o    = addr_q;
            end
            CWR: begin
                cache_cs_o       = 1'b1;
                cache_we_o       = 1'b1;
                cache_set_sel_o  = '1;
                cache_addr_o     = addr_q;
                cache_wdata_o    = wdata_q;
                cache_wdata_oe_o = 1'b1;
            end
            MWR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            RF_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = refillAddr;
            end
            RF_WR: begin
                cache_cs_o       = 1'b1;
                cache_rpe_o      = 1'b1;
                cache_set_sel_o  = victimOneHot;
                cache_addr_o     = refillAddr;
                cache_wdata_o    = fill_q;
                cache_wdata_oe_o = 1'b1;
            end
            DONE: begin
                cpu_ready_o = 1'b1;
            end
            default: begin
                cpu_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
//   Two controller instances share one clock:
//     inst 0 : NUMBER_OF_SETS=1, BLOCK_SIZE=4  (one beat per refill)
//     inst 1 : NUMBER_OF_SETS=2, BLOCK_SIZE=16 (four beats per refill)
//   Each has a behavioural cache array (per-set tagged lines, combinational
//   hit) and a word memory that acks after 0-3 random wait cycles.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

    typedef struct {
        int          inst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        int          expLat;
        int          expRpe;
        int          expCwe;
        int          expMwr;
        int          expMrd;
    } vec_t;

    logic clk;

    logic [1:0]       rst;
    logic [1:0]       cpuReq;
    logic [1:0]       cpuWe;
    logic [1:0][31:0] cpuAddr;
    logic [1:0][31:0] cpuWdata;
    logic [1:0][31:0] cpuRdata;
    logic [1:0]       cpuReady;
    logic [1:0][31:0] cacheAddr;
    logic [1:0]       cacheCs;
    logic [1:0]       cacheWe;
    logic [1:0]       cacheRe;
    logic [1:0]       cacheRpe;
    logic [0:0]       setSel0;
    logic [1:0]       setSel1;
    logic [1:0][1:0]  setSel;
    logic [1:0][31:0] cacheWdata;
    logic [1:0]       cacheOe;
    logic [1:0][31:0] cacheRdata;
    logic [1:0]       cacheHit;
    logic [1:0]       memReq;
    logic [1:0]       memWe;
    logic [1:0][31:0] memAddr;
    logic [1:0][31:0] memWdata;
    logic [1:0][31:0] memRdata;
    logic [1:0]       memAck;

    logic        lineValid [2][2][16];
    logic [31:0] lineTag   [2][2][16];
    logic [31:0] lineData  [2][2][16][4];
    logic [31:0] memArr    [2][1024];

    logic [1:0] holdAck;
    int waitCnt [2];
    int delayCnt [2];
    int rpeCnt [2];
    int cweCnt [2];
    int mwrCnt [2];
    int mrdCnt [2];
    int oeReViol;
    logic [1:0]  rpeSelLog [$];
    logic [31:0] rpeAddrLog [$];

    int checks;
    int failures;

    vec_t vecs [11];

    assign setSel[0] = {1'b0, setSel0};
    assign setSel[1] = setSel1;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(4), .NUMBER_OF_SETS(1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .cpu_req_i(cpuReq[0]), .cpu_we_i(cpuWe[0]), .cpu_addr_i(cpuAddr[0]),
        .cpu_wdata_i(cpuWdata[0]), .cpu_rdata_o(cpuRdata[0]), .cpu_ready_o(cpuReady[0]),
        .cache_addr_o(cacheAddr[0]), .cache_cs_o(cacheCs[0]), .cache_we_o(cacheWe[0]),
        .cache_re_o(cacheRe[0]), .cache_rpe_o(cacheRpe[0]), .cache_set_sel_o(setSel0),
        .cache_wdata_o(cacheWdata[0]), .cache_wdata_oe_o(cacheOe[0]),
        .cache_rdata_i(cacheRdata[0]), .cache_hit_i(cacheHit[0]),
        .mem_req_o(memReq[0]), .mem_we_o(memWe[0]), .mem_addr_o(memAddr[0]),
        .mem_wdata_o(memWdata[0]), .mem_rdata_i(memRdata[0]), .mem_ack_i(memAck[0])
    );

    cache_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(16), .NUMBER_OF_SETS(2)
    ) dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .cpu_req_i(cpuReq[1]), .cpu_we_i(cpuWe[1]), .cpu_addr_i(cpuAddr[1]),
        .cpu_wdata_i(cpuWdata[1]), .cpu_rdata_o(cpuRdata[1]), .cpu_ready_o(cpuReady[1]),
        .cache_addr_o(cacheAddr[1]), .cache_cs_o(cacheCs[1]), .cache_we_o(cacheWe[1]),
        .cache_re_o(cacheRe[1]), .cache_rpe_o(cacheRpe[1]), .cache_set_sel_o(setSel1),
        .cache_wdata_o(cacheWdata[1]), .cache_wdata_oe_o(cacheOe[1]),
        .cache_rdata_i(cacheRdata[1]), .cache_hit_i(cacheHit[1]),
        .mem_req_o(memReq[1]), .mem_we_o(memWe[1]), .mem_addr_o(memAddr[1]),
        .mem_wdata_o(memWdata[1]), .mem_rdata_i(memRdata[1]), .mem_ack_i(memAck[1])
    );

    function automatic int blockSize(input int inst);
        return (inst == 0) ? 4 : 16;
    endfunction

    function automatic int numSets(input int inst);
        return (inst == 0) ? 1 : 2;
    endfunction

    function automatic int lineIdx(input int inst, input logic [31:0] a);
        return int'((a / 32'(blockSize(inst))) % 32'd16);
    endfunction

    function automatic logic [31:0] tagOf(input int inst, input logic [31:0] a);
        return a / 32'(blockSize(inst));
    endfunction

    function automatic int wordOf(input int inst, input logic [31:0] a);
        return int'((a % 32'(blockSize(inst))) / 32'd4);
    endfunction

    // Cache array lookup: any selected set holding a matching valid line hits.
    always @* begin
        for (int i = 0; i < 2; i++) begin
            cacheHit[i]   = 1'b0;
            cacheRdata[i] = '0;
            if (cacheCs[i] && cacheRe[i]) begin
                for (int s = 0; s < 2; s++) begin
                    if (s < numSets(i) && setSel[i][s] &&
                        lineValid[i][s][lineIdx(i, cacheAddr[i])] &&
                        lineTag[i][s][lineIdx(i, cacheAddr[i])] == tagOf(i, cacheAddr[i])) begin
                        cacheHit[i]   = 1'b1;
                        cacheRdata[i] = lineData[i][s][lineIdx(i, cacheAddr[i])][wordOf(i, cacheAddr[i])];
                    end
                end
            end
        end
    end

    // Memory acks combinationally once the random wait has elapsed, so a
    // zero wait acks in the first request cycle.
    always @* begin
        for (int i = 0; i < 2; i++) begin
            memAck[i]   = memReq[i] && !holdAck[i] && (waitCnt[i] == delayCnt[i]);
            memRdata[i] = memArr[i][memAddr[i][11:2]];
        end
    end

    // Cache and memory state updates plus event counters.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                waitCnt[i] <= 0;
            end else if (memReq[i]) begin
                if (memAck[i]) begin
                    waitCnt[i]  <= 0;
                    delayCnt[i] <= int'($urandom_range(3, 0));
                    if (memWe[i]) begin
                        memArr[i][memAddr[i][11:2]] <= memWdata[i];
                        mwrCnt[i] = mwrCnt[i] + 1;
                    end else begin
                        mrdCnt[i] = mrdCnt[i] + 1;
                    end
                end else begin
                    waitCnt[i] <= waitCnt[i] + 1;
                end
            end
            if (cacheOe[i] && cacheRe[i]) oeReViol = oeReViol + 1;
            if (cacheCs[i] && cacheRpe[i]) begin
                rpeCnt[i] = rpeCnt[i] + 1;
                if (i == 1) begin
                    rpeSelLog.push_back(setSel[1]);
                    rpeAddrLog.push_back(cacheAddr[1]);
                end
                for (int s = 0; s < 2; s++) begin
                    if (s < numSets(i) && setSel[i][s]) begin
                        if (!lineValid[i][s][lineIdx(i, cacheAddr[i])] ||
                            lineTag[i][s][lineIdx(i, cacheAddr[i])] != tagOf(i, cacheAddr[i])) begin
                            lineValid[i][s][lineIdx(i, cacheAddr[i])] <= 1'b1;
                            lineTag[i][s][lineIdx(i, cacheAddr[i])]   <= tagOf(i, cacheAddr[i]);
                            for (int w = 0; w < 4; w++) lineData[i][s][lineIdx(i, cacheAddr[i])][w] <= '0;
                        end
                        lineData[i][s][lineIdx(i, cacheAddr[i])][wordOf(i, cacheAddr[i])] <= cacheWdata[i];
                    end
                end
            end
            if (cacheCs[i] && cacheWe[i]) begin
                cweCnt[i] = cweCnt[i] + 1;
                for (int s = 0; s < 2; s++) begin
                    if (s < numSets(i) && setSel[i][s] &&
                        lineValid[i][s][lineIdx(i, cacheAddr[i])] &&
                        lineTag[i][s][lineIdx(i, cacheAddr[i])] == tagOf(i, cacheAddr[i])) begin
                        lineData[i][s][lineIdx(i, cacheAddr[i])][wordOf(i, cacheAddr[i])] <= cacheWdata[i];
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issue one access and hold the request until cpu_ready (bounded).
    task automatic applyStimulus(input int inst, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int lat, output bit timedOut);
        @(negedge clk);
        cpuWe[inst]    = we;
        cpuAddr[inst]  = addr;
        cpuWdata[inst] = wdata;
        cpuReq[inst]   = 1'b1;
        rdata          = '0;
        lat            = 0;
        timedOut       = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            lat = lat + 1;
            if (cpuReady[inst]) begin
                timedOut = 1'b0;
                rdata    = cpuRdata[inst];
                break;
            end
        end
        cpuReq[inst] = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input int n);
        logic [31:0] rd;
        int lat;
        bit timedOut;
        int rpe0, cwe0, mwr0, mrd0;
        rpe0 = rpeCnt[v.inst];
        cwe0 = cweCnt[v.inst];
        mwr0 = mwrCnt[v.inst];
        mrd0 = mrdCnt[v.inst];
        applyStimulus(v.inst, v.we, v.addr, v.wdata, rd, lat, timedOut);
        checkOutput($sformatf("v%0d_timeout", n), {63'd0, timedOut}, 64'd0);
        checkOutput($sformatf("v%0d_rdata", n), {32'd0, rd}, {32'd0, v.expRdata});
        if (v.expLat != 0) checkOutput($sformatf("v%0d_latency", n), 64'(lat), 64'(v.expLat));
        @(negedge clk);
        checkOutput($sformatf("v%0d_readyPulse", n), {63'd0, cpuReady[v.inst]}, 64'd0);
        checkOutput($sformatf("v%0d_rpeBeats", n), 64'(rpeCnt[v.inst] - rpe0), 64'(v.expRpe));
        checkOutput($sformatf("v%0d_cacheWe", n), 64'(cweCnt[v.inst] - cwe0), 64'(v.expCwe));
        checkOutput($sformatf("v%0d_memWrites", n), 64'(mwrCnt[v.inst] - mwr0), 64'(v.expMwr));
        checkOutput($sformatf("v%0d_memReads", n), 64'(mrdCnt[v.inst] - mrd0), 64'(v.expMrd));
    endtask

    task automatic checkAllZero(input int inst, input string tag);
        checkOutput({tag, "_dataOuts"},
                    {32'd0, cpuRdata[inst] | cacheAddr[inst] | cacheWdata[inst] | memAddr[inst] | memWdata[inst]},
                    64'd0);
        checkOutput({tag, "_ctlOuts"},
                    {54'd0, cpuReady[inst], cacheCs[inst], cacheWe[inst], cacheRe[inst], cacheRpe[inst],
                     setSel[inst], cacheOe[inst], memReq[inst], memWe[inst]},
                    64'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  expSel;
        logic [31:0] expAddr;
        bit          sawReq;
        vec_t        v;

        checks   = 0;
        failures = 0;
        oeReViol = 0;
        rst      = 2'b11;
        cpuReq   = '0;
        cpuWe    = '0;
        cpuAddr  = '0;
        cpuWdata = '0;
        holdAck  = '0;
        for (int i = 0; i < 2; i++) begin
            waitCnt[i]  = 0;
            delayCnt[i] = 0;
            rpeCnt[i]   = 0;
            cweCnt[i]   = 0;
            mwrCnt[i]   = 0;
            mrdCnt[i]   = 0;
            for (int w = 0; w < 1024; w++) memArr[i][w] = 32'h5A00_0000 ^ 32'(w * 4);
            for (int s = 0; s < 2; s++) begin
                for (int l = 0; l < 16; l++) begin
                    lineValid[i][s][l] = 1'b0;
                    lineTag[i][s][l]   = '0;
                    for (int w = 0; w < 4; w++) lineData[i][s][l][w] = '0;
                end
            end
        end
        memArr[0][32'h100 >> 2] = 32'hDEAD_BEEF;

        //         inst we    addr          wdata         expRdata      lat rpe cwe mwr mrd
        vecs[0]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 0, 1};
        vecs[1]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2, 0, 0, 0, 0};
        vecs[2]  = '{0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 1, 1, 0};
        vecs[3]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, 2, 0, 0, 0, 0};
        vecs[4]  = '{0, 1'b1, 32'h0000_0200, 32'hAAAA_5555, 32'h1234_5678, 0, 0, 0, 1, 0};
        vecs[5]  = '{0, 1'b0, 32'h0000_0200, 32'h0,         32'hAAAA_5555, 0, 1, 0, 0, 1};
        vecs[6]  = '{0, 1'b0, 32'h0000_0206, 32'h0,         32'h5A00_0204, 0, 1, 0, 0, 1};
        vecs[7]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'h5A00_0000, 0, 4, 0, 0, 4};
        vecs[8]  = '{1, 1'b0, 32'h0000_0400, 32'h0,         32'h5A00_0400, 0, 4, 0, 0, 4};
        vecs[9]  = '{1, 1'b0, 32'h0000_0800, 32'h0,         32'h5A00_0800, 0, 4, 0, 0, 4};
        vecs[10] = '{1, 1'b0, 32'h0000_0404, 32'h0,         32'h5A00_0404, 2, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 2'b00;
        checkAllZero(0, "reset0");
        checkAllZero(1, "reset1");

        for (int n = 0; n < 11; n++) runVector(vecs[n], n);

        // Refill order and victim rotation on the two-set instance.
        checkOutput("rpeLogSize", 64'(rpeSelLog.size()), 64'd12);
        for (int k = 0; k < 12 && k < rpeSelLog.size(); k++) begin
            expSel  = ((k / 4) == 1) ? 2'b01 : 2'b10;
            expAddr = 32'((k / 4) * 32'h400 + (k % 4) * 4);
            checkOutput($sformatf("rpeSel%0d", k), {62'd0, rpeSelLog[k]}, {62'd0, expSel});
            checkOutput($sformatf("rpeAddr%0d", k), {32'd0, rpeAddrLog[k]}, {32'd0, expAddr});
        end

        // Reset while a refill waits for memory, then a fresh request.
        holdAck[0] = 1'b1;
        @(negedge clk);
        cpuWe[0]   = 1'b0;
        cpuAddr[0] = 32'h0000_0300;
        cpuReq[0]  = 1'b1;
        sawReq     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (memReq[0]) begin
                sawReq = 1'b1;
                break;
            end
        end
        checkOutput("rfReqReached", {63'd0, sawReq}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst[0]    = 1'b1;
        cpuReq[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero(0, "midRefillRst");
        rst[0]     = 1'b0;
        holdAck[0] = 1'b0;
        v = '{0, 1'b0, 32'h0000_0300, 32'h0, 32'h5A00_0300, 0, 1, 0, 0, 1};
        runVector(v, 11);

        checkOutput("oeWithRe", 64'(oeReViol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
